// File: rtl/upack_channel_sequencer_pkg.sv
// Shared definitions for the timestamped unpacker channel sequencer.
// Holds the default channel count and the sequencer state encoding.
package upack_channel_sequencer_pkg;

  localparam int NUM_OF_CHANNELS_DEF = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } upack_state_e;

endpackage

// File: rtl/count_bits.sv
// Population count of a bit vector.
module count_bits #(
  parameter int BIT_WIDTH = 4
) (
  input  logic [BIT_WIDTH-1:0]             data,
  output logic [$clog2(BIT_WIDTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(BIT_WIDTH + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < BIT_WIDTH; i++) begin
      count = count + CNT_W'(data[i]);
    end
  end

endmodule

// File: rtl/upack_channel_sequencer_next_channel.sv
// Masked priority encoder: next set bit above ptr (wrapping to the lowest),
// plus the lowest and highest set bits of the mask (0 when the mask is empty).
module upack_next_channel
  import upack_channel_sequencer_pkg::*;
#(
  parameter int NUM_OF_CHANNELS = NUM_OF_CHANNELS_DEF,
  localparam int CH_W = $clog2(NUM_OF_CHANNELS)
) (
  input  logic [NUM_OF_CHANNELS-1:0] mask,
  input  logic [CH_W-1:0]            ptr,
  output logic [CH_W-1:0]            next_ch,
  output logic [CH_W-1:0]            low_ch,
  output logic [CH_W-1:0]            high_ch
);

  logic found_next;

  always_comb begin
    low_ch     = '0;
    high_ch    = '0;
    next_ch    = '0;
    found_next = 1'b0;
    // Descending scan: the last hit is the lowest set bit / nearest bit above ptr.
    for (int i = NUM_OF_CHANNELS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        low_ch = CH_W'(i);
        if (CH_W'(i) > ptr) begin
          next_ch    = CH_W'(i);
          found_next = 1'b1;
        end
      end
    end
    for (int i = 0; i < NUM_OF_CHANNELS; i++) begin
      if (mask[i]) high_ch = CH_W'(i);
    end
    if (!found_next) next_ch = low_ch;
  end

endmodule

// File: rtl/upack_channel_sequencer.sv
// Walks the enabled channels of one packed upstream word, one channel per
// output beat; a new enable mask takes effect only at a word boundary.
module upack_channel_sequencer
  import upack_channel_sequencer_pkg::*;
#(
  parameter int NUM_OF_CHANNELS = NUM_OF_CHANNELS_DEF,
  localparam int CH_W  = $clog2(NUM_OF_CHANNELS),
  localparam int CNT_W = $clog2(NUM_OF_CHANNELS + 1)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_OF_CHANNELS-1:0] enable,
  input  logic                       cfg_load,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [CH_W-1:0]            m_channel,
  output logic                       m_first,
  output logic                       m_last,
  output logic [CNT_W-1:0]           num_enabled,
  output logic                       busy,
  output upack_state_e               dbg_state
);

  // Handshake: a beat transfers when m_valid & m_ready; s_ready pulses only on
  // the transfer of the last enabled channel, consuming the upstream word.

  upack_state_e               state_q, state_d;
  logic [NUM_OF_CHANNELS-1:0] enable_q, enable_d;
  logic [NUM_OF_CHANNELS-1:0] shadow_q, shadow_d;
  logic                       pend_q, pend_d;
  logic [CH_W-1:0]            ptr_q, ptr_d;
  logic [CNT_W-1:0]           num_enabled_q, num_enabled_d;

  logic [CH_W-1:0]            cur_next, cur_low, cur_high;
  logic [CH_W-1:0]            new_next, new_low, new_high;
  logic [NUM_OF_CHANNELS-1:0] apply_mask;
  logic [CNT_W-1:0]           apply_cnt;
  logic                       run, hs, word_done, boundary, apply;

  upack_next_channel #(.NUM_OF_CHANNELS(NUM_OF_CHANNELS)) u_cur_nc (
    .mask    (enable_q),
    .ptr     (ptr_q),
    .next_ch (cur_next),
    .low_ch  (cur_low),
    .high_ch (cur_high)
  );

  upack_next_channel #(.NUM_OF_CHANNELS(NUM_OF_CHANNELS)) u_new_nc (
    .mask    (apply_mask),
    .ptr     ('0),
    .next_ch (new_next),
    .low_ch  (new_low),
    .high_ch (new_high)
  );

  count_bits #(.BIT_WIDTH(NUM_OF_CHANNELS)) u_count (
    .data  (apply_mask),
    .count (apply_cnt)
  );

  always_comb begin
    run       = (state_q == ST_RUN);
    m_valid   = run & s_valid;
    m_channel = run ? ptr_q : '0;
    m_first   = run & (ptr_q == cur_low);
    m_last    = run & (ptr_q == cur_high);
    hs        = m_valid & m_ready;
    s_ready   = hs & m_last;
    word_done = s_ready;
    busy      = run & (ptr_q != cur_low);
    // A first-beat transfer of a multi-channel word also leaves the boundary.
    boundary  = (!busy & !(hs & !m_last)) | word_done;
    apply     = (cfg_load & boundary) | (pend_q & word_done);
    apply_mask = cfg_load ? enable : shadow_q;

    state_d       = state_q;
    enable_d      = enable_q;
    shadow_d      = shadow_q;
    pend_d        = pend_q;
    ptr_d         = ptr_q;
    num_enabled_d = num_enabled_q;

    if (hs) ptr_d = m_last ? cur_low : cur_next;

    if (apply) begin
      enable_d      = apply_mask;
      num_enabled_d = apply_cnt;
      ptr_d         = new_low;
      state_d       = (|apply_mask) ? ST_RUN : ST_IDLE;
      pend_d        = 1'b0;
    end else if (cfg_load) begin
      pend_d   = 1'b1;
      shadow_d = enable;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      enable_q      <= '0;
      shadow_q      <= '0;
      pend_q        <= 1'b0;
      ptr_q         <= '0;
      num_enabled_q <= '0;
    end else begin
      state_q       <= state_d;
      enable_q      <= enable_d;
      shadow_q      <= shadow_d;
      pend_q        <= pend_d;
      ptr_q         <= ptr_d;
      num_enabled_q <= num_enabled_d;
    end
  end

  assign num_enabled = num_enabled_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_upack_channel_sequencer.sv
// Directed bench for upack_channel_sequencer with hand-computed expectations.
module tb_upack_channel_sequencer;
  import upack_channel_sequencer_pkg::*;

  logic         clk;
  logic         resetn;
  logic [3:0]   enable;
  logic         cfg_load;
  logic         s_valid;
  logic         s_ready;
  logic         m_valid;
  logic         m_ready;
  logic [1:0]   m_channel;
  logic         m_first;
  logic         m_last;
  logic [2:0]   num_enabled;
  logic         busy;
  upack_state_e dbg_state;

  int n_pass;
  int n_total;

  upack_channel_sequencer dut (
    .clk         (clk),
    .resetn      (resetn),
    .enable      (enable),
    .cfg_load    (cfg_load),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_channel   (m_channel),
    .m_first     (m_first),
    .m_last      (m_last),
    .num_enabled (num_enabled),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Checks the full beat-side output set for the current cycle.
  task automatic beat(input string tag, input logic v, input logic [1:0] ch,
                      input logic f, input logic l, input logic sr);
    chk({tag, ".m_valid"}, 32'(m_valid), 32'(v));
    chk({tag, ".m_channel"}, 32'(m_channel), 32'(ch));
    chk({tag, ".m_first"}, 32'(m_first), 32'(f));
    chk({tag, ".m_last"}, 32'(m_last), 32'(l));
    chk({tag, ".s_ready"}, 32'(s_ready), 32'(sr));
  endtask

  // Advance one clock; inputs are driven right after, outputs checked #1 later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    resetn   = 1'b0;
    enable   = 4'b0000;
    cfg_load = 1'b0;
    s_valid  = 1'b1;
    m_ready  = 1'b1;
    cyc();
    #1;
    beat("rst", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("rst.num_enabled", 32'(num_enabled), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.state", 32'(dbg_state), 32'(ST_IDLE));

    // Test 1: mask 1011, full throughput.
    resetn = 1'b1; enable = 4'b1011; cfg_load = 1'b1;
    #1;
    chk("t1.idle_valid", 32'(m_valid), 32'd0);
    cyc();
    cfg_load = 1'b0;
    #1;
    chk("t1.num_enabled", 32'(num_enabled), 32'd3);
    chk("t1.state", 32'(dbg_state), 32'(ST_RUN));
    for (int k = 0; k < 2; k++) begin
      beat("t1.b0", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
      cyc(); #1;
      beat("t1.b1", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
      chk("t1.busy", 32'(busy), 32'd1);
      cyc(); #1;
      beat("t1.b3", 1'b1, 2'd3, 1'b0, 1'b1, 1'b1);
      cyc(); #1;
    end

    // Test 2: single channel 2 (loaded at a boundary with no transfer).
    m_ready = 1'b0; enable = 4'b0100; cfg_load = 1'b1;
    cyc();
    cfg_load = 1'b0; m_ready = 1'b1;
    #1;
    chk("t2.num_enabled", 32'(num_enabled), 32'd1);
    beat("t2.b0", 1'b1, 2'd2, 1'b1, 1'b1, 1'b1);
    cyc(); #1;
    beat("t2.b1", 1'b1, 2'd2, 1'b1, 1'b1, 1'b1);
    m_ready = 1'b0;
    #1;
    beat("t2.stall", 1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
    chk("t2.busy", 32'(busy), 32'd0);

    // Test 3: mask 1111 with m_ready pattern 1,0,0,1,1,1.
    enable = 4'b1111; cfg_load = 1'b1;
    cyc();
    cfg_load = 1'b0; m_ready = 1'b1;
    #1;
    chk("t3.num_enabled", 32'(num_enabled), 32'd4);
    beat("t3.a", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    cyc(); m_ready = 1'b0; #1;
    beat("t3.b", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    cyc(); #1;
    beat("t3.c", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    cyc(); m_ready = 1'b1; #1;
    beat("t3.d", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    cyc(); #1;
    beat("t3.e", 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    cyc(); #1;
    beat("t3.f", 1'b1, 2'd3, 1'b0, 1'b1, 1'b1);
    cyc(); #1;

    // Test 4: reconfigure to 0011 mid-word (after ch1 accepted).
    beat("t4.ch0", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    cyc(); #1;
    beat("t4.ch1", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    cyc();
    enable = 4'b0011; cfg_load = 1'b1;
    #1;
    beat("t4.ch2", 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    cyc();
    cfg_load = 1'b0; enable = 4'b0000;
    #1;
    beat("t4.ch3", 1'b1, 2'd3, 1'b0, 1'b1, 1'b1);
    chk("t4.num_old", 32'(num_enabled), 32'd4);
    cyc(); #1;
    chk("t4.num_new", 32'(num_enabled), 32'd2);
    beat("t4.n0", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    cyc(); #1;
    beat("t4.n1", 1'b1, 2'd1, 1'b0, 1'b1, 1'b1);
    cyc();

    // s_valid drop: channel holds and resumes.
    s_valid = 1'b0;
    #1;
    beat("drop.a", 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    cyc(); #1;
    beat("drop.b", 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    s_valid = 1'b1;
    #1;
    beat("drop.resume", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);

    // Test 5: all-zero mask, then 0001.
    m_ready = 1'b0; enable = 4'b0000; cfg_load = 1'b1;
    cyc();
    cfg_load = 1'b0; m_ready = 1'b1;
    #1;
    beat("t5.idle0", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("t5.num", 32'(num_enabled), 32'd0);
    chk("t5.state", 32'(dbg_state), 32'(ST_IDLE));
    cyc(); cyc(); #1;
    beat("t5.idle2", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    enable = 4'b0001; cfg_load = 1'b1;
    cyc();
    cfg_load = 1'b0;
    #1;
    beat("t5.resume", 1'b1, 2'd0, 1'b1, 1'b1, 1'b1);
    chk("t5.num1", 32'(num_enabled), 32'd1);

    // Test 6: reset while ptr=2 with a pending config.
    m_ready = 1'b0; enable = 4'b1111; cfg_load = 1'b1;
    cyc();
    cfg_load = 1'b0; m_ready = 1'b1;
    cyc(); cyc();
    m_ready = 1'b0; enable = 4'b0001; cfg_load = 1'b1;
    #1;
    beat("t6.ptr2", 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    chk("t6.busy", 32'(busy), 32'd1);
    cyc();
    cfg_load = 1'b0; resetn = 1'b0; m_ready = 1'b1;
    cyc();
    resetn = 1'b1;
    #1;
    beat("t6.after_rst", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("t6.num", 32'(num_enabled), 32'd0);
    chk("t6.busy0", 32'(busy), 32'd0);
    cyc(); cyc(); #1;
    beat("t6.still_idle", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("t6.state", 32'(dbg_state), 32'(ST_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
